// File: rtl/fifo_rd_port_if.sv
// Consumer-side bundle of the FIFO read port: FWFT data/handshake plus status flags.
// The rlevel signal exists only when FIFO_RD_LEVEL_EN is defined.
interface fifo_rd_port_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic [DSIZE-1:0] rdata;
  logic             rvalid;
  logic             rready;
  logic             rempty;
  logic             raempty;
`ifdef FIFO_RD_LEVEL_EN
  logic [ASIZE:0]   rlevel;

  modport master (output rdata, rvalid, rempty, raempty, rlevel, input rready);
  modport slave  (input rdata, rvalid, rempty, raempty, rlevel, output rready);
`else
  modport master (output rdata, rvalid, rempty, raempty, input rready);
  modport slave  (input rdata, rvalid, rempty, raempty, output rready);
`endif
endinterface

// File: rtl/fifo_rd_port.sv
// Read-side controller of the single-clock FIFO: read pointer, FWFT output register, status flags.
// Optional registered occupancy output rlevel is enabled by defining FIFO_RD_LEVEL_EN.
module fifo_rd_port #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AE_LEVEL = 2
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [ASIZE:0]   wptr,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  fifo_rd_port_if.master   rd
);

  localparam logic [ASIZE:0] AE_LVL = (ASIZE+1)'(AE_LEVEL);

  logic [DSIZE-1:0] data_p0;
  logic             vld_p0;
  logic [ASIZE:0]   rptr_p0;
  logic             ae_p0;

  logic             mem_empty;
  logic             load;
  logic             drain;
  logic [ASIZE:0]   rptr_nxt;
  logic             vld_nxt;
  logic [ASIZE:0]   occ_nxt;
  logic             ae_nxt;

  always_comb begin
    mem_empty = (rptr_p0 == wptr);
    load      = (!vld_p0 || rd.rready) && !mem_empty;
    drain     = vld_p0 && rd.rready && mem_empty;
    rptr_nxt  = rptr_p0 + {{ASIZE{1'b0}}, load};
    vld_nxt   = vld_p0;
    if (load)
      vld_nxt = 1'b1;
    else if (drain)
      vld_nxt = 1'b0;
    // Occupancy after this edge: words still in memory plus the one held in the output register.
    occ_nxt   = (wptr - rptr_nxt) + {{ASIZE{1'b0}}, vld_nxt};
    ae_nxt    = (occ_nxt <= AE_LVL);
  end

  // Output register / pointer stage
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
      rptr_p0 <= '0;
      ae_p0   <= 1'b1;
    end else begin
      if (load)
        data_p0 <= mem_rdata;
      vld_p0  <= vld_nxt;
      rptr_p0 <= rptr_nxt;
      ae_p0   <= ae_nxt;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [ASIZE:0] level_p0;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst)
      level_p0 <= '0;
    else
      level_p0 <= occ_nxt;
  end

  assign rd.rlevel = level_p0;
`endif

  assign raddr      = rptr_p0[ASIZE-1:0];
  assign rptr       = rptr_p0;
  assign rd.rdata   = data_p0;
  assign rd.rvalid  = vld_p0;
  assign rd.rempty  = !vld_p0;
  assign rd.raempty = ae_p0;

endmodule

// File: tb/tb_fifo_rd_port.sv
// Scoreboard bench for fifo_rd_port: a behavioural memory/writer drives wptr, a monitor checks
// every cycle against a word-count occupancy model and an expected-data queue.
module tb_fifo_rd_port;
  localparam int DSIZE    = 8;
  localparam int ASIZE    = 4;
  localparam int DEPTH    = 1 << ASIZE;
  localparam int AE_LEVEL = 2;

  logic             rclk = 1'b0;
  logic             rrst = 1'b1;
  logic [ASIZE:0]   wptr = '0;
  logic [DSIZE-1:0] mem_rdata;
  logic [ASIZE-1:0] raddr;
  logic [ASIZE:0]   rptr;
  logic [DSIZE-1:0] mem [DEPTH];

  fifo_rd_port_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) rd_if ();

  fifo_rd_port #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AE_LEVEL(AE_LEVEL)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .wptr      (wptr),
    .mem_rdata (mem_rdata),
    .raddr     (raddr),
    .rptr      (rptr),
    .rd        (rd_if)
  );

  always #5 rclk = ~rclk;
  assign mem_rdata = mem[raddr];

  int               written = 0;
  logic [DSIZE-1:0] exp_q [$];
  int               m_rd  = 0;
  bit               m_vld = 1'b0;
  int               m_occ = 0;
  int               n_vec = 0;
  int               n_err = 0;
  bit               end_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT against the model, then advances the model for the coming edge.
  initial begin
    int avail;
    forever begin
      @(negedge rclk or posedge rrst);
      if (end_req) begin
        chk("leftover_words", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
      if (rrst) begin
        #1;
        chk("rst_rvalid", rd_if.rvalid, 0);
        chk("rst_rempty", rd_if.rempty, 1);
        chk("rst_raempty", rd_if.raempty, 1);
        chk("rst_rptr", rptr, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_rdata", rd_if.rdata, 0);
`ifdef FIFO_RD_LEVEL_EN
        chk("rst_rlevel", rd_if.rlevel, 0);
`endif
        m_rd  = 0;
        m_vld = 1'b0;
        m_occ = 0;
        exp_q.delete();
      end else begin
        chk("rvalid", rd_if.rvalid, m_vld);
        chk("rempty", rd_if.rempty, !m_vld);
        chk("rptr", rptr, m_rd % (2 * DEPTH));
        chk("raddr", raddr, m_rd % DEPTH);
        chk("raempty", rd_if.raempty, m_occ <= AE_LEVEL);
`ifdef FIFO_RD_LEVEL_EN
        chk("rlevel", rd_if.rlevel, m_occ);
`endif
        if (m_vld && rd_if.rvalid) begin
          if (exp_q.size() == 0)
            chk("unexpected_word", rd_if.rdata, 32'hFFFF_FFFF);
          else begin
            chk("rdata", rd_if.rdata, exp_q[0]);
            if (rd_if.rready)
              void'(exp_q.pop_front());
          end
        end
        avail = written - m_rd;
        if ((!m_vld || rd_if.rready) && avail > 0) begin
          m_rd++;
          m_vld = 1'b1;
        end else if (m_vld && rd_if.rready) begin
          m_vld = 1'b0;
        end
        m_occ = written - m_rd + int'(m_vld);
      end
    end
  end

  // One stimulus cycle: inputs change just after the rising edge; writes never overflow memory.
  task automatic step(input bit wr, input logic [DSIZE-1:0] d, input bit rdy);
    @(posedge rclk);
    #1;
    rd_if.rready = rdy;
    if (wr && !rrst && (written - m_rd) < DEPTH) begin
      mem[written % DEPTH] = d;
      exp_q.push_back(d);
      written++;
      wptr = written[ASIZE:0];
    end
  endtask

  task automatic mid_cycle_reset();
    @(posedge rclk);
    #3;
    rrst    = 1'b1;
    written = 0;
    wptr    = '0;
    rd_if.rready = 1'b0;
    #10;
    rrst    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rd_if.rready = 1'b0;
    repeat (3) @(posedge rclk);
    #3 rrst = 1'b0;

    // Single word, held under back-pressure
    step(1, 8'hA5, 0);
    repeat (6) step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    // Fill memory plus output register, then drain at full rate across the pointer wrap
    for (int i = 0; i <= DEPTH; i++) step(1, 8'(i), 0);
    repeat (2) step(0, 0, 0);
    repeat (DEPTH + 4) step(0, 0, 1);

    // Streaming writer at one word per cycle
    for (int i = 0; i < 40; i++) step(1, 8'($urandom), 1);
    repeat (4) step(0, 0, 1);

    // Stall pattern with three words queued
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    repeat (4) step(0, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);

    // Reset while a word is presented, then single-word latency after release
    for (int i = 0; i < 4; i++) step(1, 8'(8'h50 + i), 0);
    mid_cycle_reset();
    step(1, 8'h3C, 0);
    repeat (3) step(0, 0, 0);
    repeat (2) step(0, 0, 1);

    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
    repeat (DEPTH + 6) step(0, 0, 1);

    end_req = 1'b1;
    repeat (5) @(posedge rclk);
    $display("FAIL end_of_test: monitor did not reach summary");
    $fatal(1);
  end
endmodule
